// File: rtl/wavetable_reader.sv
// Read-side sequencer for wavetable_ram: fetches one entry per TICKS_PER_ENTRY ticks
// and presents {wfm_l, wfm_r, factor} with a one-cycle entry_valid strobe.
module wavetable_reader #(
    parameter int RAM_SIZE        = 61,
    parameter int LOOP_START      = 0,
    parameter int TICKS_PER_ENTRY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wtb_start,
    input  logic       wtb_stop,
    input  logic       tick,
    output logic       wtb_ram_re,
    output logic [5:0] wtb_ram_addr_r,
    input  logic [7:0] wtb_ram_wfm_l_r,
    input  logic [7:0] wtb_ram_wfm_r_r,
    input  logic [7:0] wtb_ram_factor_r,
    output logic [7:0] wfm_l,
    output logic [7:0] wfm_r,
    output logic [7:0] factor,
    output logic       entry_valid,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ      = 2'd1,
        CAPTURE   = 2'd2,
        WAIT_TICK = 2'd3
    } state_t;

    localparam logic [5:0]  LAST_ADDR = 6'(RAM_SIZE - 1);
    localparam logic [5:0]  LOOP_ADDR = 6'(LOOP_START);
    localparam logic [15:0] TPE       = 16'(TICKS_PER_ENTRY);

    state_t      state;
    logic [5:0]  addr;
    logic [15:0] tick_cnt;
    logic [7:0]  hold_l;
    logic [7:0]  hold_r;
    logic [7:0]  hold_f;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            tick_cnt <= TPE;
            hold_l   <= '0;
            hold_r   <= '0;
            hold_f   <= '0;
        end else begin
            // Capture completes even when a start or stop lands in the same cycle.
            if (state == CAPTURE) begin
                hold_l <= wtb_ram_wfm_l_r;
                hold_r <= wtb_ram_wfm_r_r;
                hold_f <= wtb_ram_factor_r;
            end
            if (wtb_start) begin
                state    <= READ;
                addr     <= '0;
                tick_cnt <= TPE;
            end else if (wtb_stop && state != IDLE) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    READ: state <= CAPTURE;
                    CAPTURE: begin
                        addr  <= (addr == LAST_ADDR) ? LOOP_ADDR : addr + 6'd1;
                        state <= WAIT_TICK;
                    end
                    WAIT_TICK: begin
                        if (tick) begin
                            if (tick_cnt == 16'd1) begin
                                tick_cnt <= TPE;
                                state    <= READ;
                            end else begin
                                tick_cnt <= tick_cnt - 16'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // entry_valid is a one-cycle strobe with no ready: the consumer must take the
    // triple in that cycle. During CAPTURE the RAM data is passed straight through,
    // afterwards the held copy keeps the outputs stable.
    assign entry_valid    = (state == CAPTURE);
    assign wfm_l          = entry_valid ? wtb_ram_wfm_l_r  : hold_l;
    assign wfm_r          = entry_valid ? wtb_ram_wfm_r_r  : hold_r;
    assign factor         = entry_valid ? wtb_ram_factor_r : hold_f;
    assign wtb_ram_re     = (state == READ);
    assign wtb_ram_addr_r = addr;
    assign busy           = (state != IDLE);
    assign state_dbg      = state;

endmodule

// File: tb/tb_wavetable_reader.sv
// Bench for wavetable_reader: two instances (loop start 10 and 0) driven in lockstep,
// checked every cycle against a fetch-schedule model plus hand-computed literals.
module tb_wavetable_reader;

    localparam int RAM_SIZE = 61;
    localparam int TPE      = 4;
    localparam int LS [2]   = '{10, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wtb_start = 1'b0;
    logic wtb_stop  = 1'b0;
    logic wtb_tick  = 1'b0;

    logic       re_o   [2];
    logic [5:0] addr_o [2];
    logic [7:0] raml   [2];
    logic [7:0] ramr   [2];
    logic [7:0] ramf   [2];
    logic [7:0] l_o    [2];
    logic [7:0] r_o    [2];
    logic [7:0] f_o    [2];
    logic       ev_o   [2];
    logic       busy_o [2];
    logic [1:0] st_o   [2];

    logic [7:0] mem_l [64];
    logic [7:0] mem_r [64];
    logic [7:0] mem_f [64];

    int checks = 0;
    int errors = 0;
    int gap = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    wavetable_reader #(.RAM_SIZE(RAM_SIZE), .LOOP_START(10), .TICKS_PER_ENTRY(TPE)) dut0 (
        .clk(clk), .rst(rst), .wtb_start(wtb_start), .wtb_stop(wtb_stop), .tick(wtb_tick),
        .wtb_ram_re(re_o[0]), .wtb_ram_addr_r(addr_o[0]),
        .wtb_ram_wfm_l_r(raml[0]), .wtb_ram_wfm_r_r(ramr[0]), .wtb_ram_factor_r(ramf[0]),
        .wfm_l(l_o[0]), .wfm_r(r_o[0]), .factor(f_o[0]),
        .entry_valid(ev_o[0]), .busy(busy_o[0]), .state_dbg(st_o[0]));

    wavetable_reader #(.RAM_SIZE(RAM_SIZE), .LOOP_START(0), .TICKS_PER_ENTRY(TPE)) dut1 (
        .clk(clk), .rst(rst), .wtb_start(wtb_start), .wtb_stop(wtb_stop), .tick(wtb_tick),
        .wtb_ram_re(re_o[1]), .wtb_ram_addr_r(addr_o[1]),
        .wtb_ram_wfm_l_r(raml[1]), .wtb_ram_wfm_r_r(ramr[1]), .wtb_ram_factor_r(ramf[1]),
        .wfm_l(l_o[1]), .wfm_r(r_o[1]), .factor(f_o[1]),
        .entry_valid(ev_o[1]), .busy(busy_o[1]), .state_dbg(st_o[1]));

    // Registered-read RAM; returns noise on cycles without a read.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (re_o[i]) begin
                raml[i] <= mem_l[addr_o[i]];
                ramr[i] <= mem_r[addr_o[i]];
                ramf[i] <= mem_f[addr_o[i]];
            end else begin
                raml[i] <= 8'($urandom);
                ramr[i] <= 8'($urandom);
                ramf[i] <= 8'($urandom);
            end
        end
    end

    function automatic logic [23:0] ent(input int a);
        logic [31:0] v;
        v = a;
        return {v[7:0], 8'(255 - a), 8'(2 * a)};
    endfunction

    task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Each fetch is scheduled as a cycle number: one after start or after the
    // TPE-th counted tick; data shows one cycle after the fetch.
    int   cyc = 0;
    bit   m_play    [2];
    int   m_re      [2];
    int   m_cap     [2];
    int   m_tcnt    [2];
    int   m_raddr   [2];
    int   m_capaddr [2];
    logic [23:0] m_held [2];

    always @(posedge clk) begin
        if (rst) begin
            cyc = 0;
            for (int i = 0; i < 2; i++) begin
                m_play[i] = 1'b0; m_re[i] = -1; m_cap[i] = -1; m_tcnt[i] = 0;
                m_raddr[i] = 0; m_capaddr[i] = 0; m_held[i] = '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (cyc == m_re[i] && !wtb_start && !wtb_stop) begin
                    m_cap[i] = cyc + 1;
                    m_capaddr[i] = m_raddr[i];
                end
                if (cyc == m_cap[i]) m_held[i] = ent(m_capaddr[i]);
                if (wtb_start) begin
                    m_play[i] = 1'b1; m_re[i] = cyc + 1; m_raddr[i] = 0; m_tcnt[i] = 0;
                end else if (wtb_stop && m_play[i]) begin
                    m_play[i] = 1'b0; m_re[i] = -1;
                end else if (m_play[i]) begin
                    if (cyc == m_cap[i])
                        m_raddr[i] = (m_raddr[i] == RAM_SIZE - 1) ? LS[i] : m_raddr[i] + 1;
                    if (wtb_tick && cyc > m_re[i] + 1) begin
                        m_tcnt[i]++;
                        if (m_tcnt[i] == TPE) begin
                            m_tcnt[i] = 0;
                            m_re[i] = cyc + 1;
                        end
                    end
                end
            end
            cyc = cyc + 1;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                chk("busy", i, 32'(busy_o[i]), 32'(m_play[i]));
                chk("ram_re", i, 32'(re_o[i]), 32'(cyc == m_re[i]));
                if (cyc == m_re[i]) chk("ram_addr", i, 32'(addr_o[i]), 32'(m_raddr[i]));
                chk("entry_valid", i, 32'(ev_o[i]), 32'(cyc == m_cap[i]));
                chk("entry", i, 32'({l_o[i], r_o[i], f_o[i]}),
                    32'((cyc == m_cap[i]) ? ent(m_capaddr[i]) : m_held[i]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tstep(input int lo, input int hi);
        if (gap == 0) begin
            wtb_tick = 1'b1;
            gap = $urandom_range(hi, lo) - 1;
        end else begin
            wtb_tick = 1'b0;
            gap--;
        end
        step();
    endtask

    task automatic wait_ev0(input string nm);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            if (ev_o[0]) found = 1'b1;
            else tstep(4, 4);
        end
        chk(nm, 0, 32'(found), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    int ev_cyc [$];
    logic [7:0] ev_val [$];
    logic [7:0] prev_l [2];
    logic [7:0] wrap_next [2];
    bit wrap_done [2];
    logic [23:0] last_ent;
    int re_count;

    initial begin
        for (int a = 0; a < 64; a++) begin
            mem_l[a] = 8'(a);
            mem_r[a] = 8'(255 - a);
            mem_f[a] = 8'(2 * a);
        end

        // reset, then idle with ticks: no reads, not busy
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        gap = 2;
        repeat (12) tstep(3, 6);
        wtb_tick = 1'b0;
        chk("idle_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("idle_entry", 0, 32'({l_o[0], r_o[0], f_o[0]}), 32'd0);

        // start: read addr 0 next cycle, entry {00,FF,00} the cycle after
        wtb_start = 1'b1;
        step();
        wtb_start = 1'b0;
        chk("start_re", 0, 32'(re_o[0]), 32'd1);
        chk("start_addr", 0, 32'(addr_o[0]), 32'd0);
        step();
        chk("start_ev", 0, 32'(ev_o[0]), 32'd1);
        chk("start_entry", 0, 32'({l_o[0], r_o[0], f_o[0]}), 32'h00FF00);
        step();

        // pacing: tick every 10 cycles
        for (int k = 0; k < 125; k++) begin
            wtb_tick = (k % 10 == 0);
            step();
            if (ev_o[0]) begin
                ev_cyc.push_back(k);
                ev_val.push_back(l_o[0]);
            end
        end
        wtb_tick = 1'b0;
        chk("pace_count", 0, 32'(ev_cyc.size()), 32'd3);
        if (ev_cyc.size() == 3) begin
            chk("pace_gap1", 0, 32'(ev_cyc[1] - ev_cyc[0]), 32'd40);
            chk("pace_gap2", 0, 32'(ev_cyc[2] - ev_cyc[1]), 32'd40);
            chk("pace_addr1", 0, 32'(ev_val[0]), 32'd1);
            chk("pace_addr2", 0, 32'(ev_val[1]), 32'd2);
            chk("pace_addr3", 0, 32'(ev_val[2]), 32'd3);
        end

        // random tick spacing, run past addr 60 on both instances
        gap = 2;
        for (int i = 0; i < 2; i++) begin
            prev_l[i] = 8'd3; wrap_next[i] = 8'hEE; wrap_done[i] = 1'b0;
        end
        for (int k = 0; k < 3000 && !(wrap_done[0] && wrap_done[1]); k++) begin
            tstep(3, 6);
            for (int i = 0; i < 2; i++) begin
                if (ev_o[i]) begin
                    if (prev_l[i] == 8'd60 && !wrap_done[i]) begin
                        wrap_next[i] = l_o[i];
                        wrap_done[i] = 1'b1;
                    end
                    prev_l[i] = l_o[i];
                end
            end
        end
        chk("wrap_ls10", 0, 32'(wrap_next[0]), 32'd10);
        chk("wrap_ls0", 1, 32'(wrap_next[1]), 32'd0);

        // stop in WAIT_TICK: outputs hold, further ticks read nothing
        wait_ev0("wait_ev_stop");
        last_ent = {l_o[0], r_o[0], f_o[0]};
        tstep(4, 4);
        wtb_stop = 1'b1;
        tstep(4, 4);
        wtb_stop = 1'b0;
        chk("stop_busy", 0, 32'(busy_o[0]), 32'd0);
        chk("stop_hold", 0, 32'({l_o[0], r_o[0], f_o[0]}), 32'(last_ent));
        re_count = 0;
        for (int k = 0; k < 40; k++) begin
            tstep(4, 4);
            if (re_o[0]) re_count++;
        end
        chk("stop_no_reads", 0, 32'(re_count), 32'd0);
        chk("stop_hold_late", 0, 32'({l_o[0], r_o[0], f_o[0]}), 32'(last_ent));

        // restart after stop
        wtb_tick = 1'b0;
        wtb_start = 1'b1;
        step();
        wtb_start = 1'b0;
        chk("restart_re", 0, 32'(re_o[0]), 32'd1);
        chk("restart_addr", 0, 32'(addr_o[0]), 32'd0);

        // start and stop together: start wins
        repeat (5) step();
        wait_ev0("wait_ev_both");
        tstep(4, 4);
        wtb_start = 1'b1;
        wtb_stop = 1'b1;
        wtb_tick = 1'b0;
        step();
        wtb_start = 1'b0;
        wtb_stop = 1'b0;
        chk("both_busy", 0, 32'(busy_o[0]), 32'd1);
        chk("both_re", 0, 32'(re_o[0]), 32'd1);
        chk("both_addr", 0, 32'(addr_o[0]), 32'd0);

        // restart landing in CAPTURE of addr 25
        begin
            bit found;
            found = 1'b0;
            gap = 2;
            for (int k = 0; k < 3000 && !found; k++) begin
                tstep(4, 4);
                if (re_o[0] && addr_o[0] == 6'd25) found = 1'b1;
            end
            chk("reach_addr25", 0, 32'(found), 32'd1);
        end
        wtb_tick = 1'b0;
        step();
        chk("mid_ev", 0, 32'(ev_o[0]), 32'd1);
        chk("mid_entry", 0, 32'({l_o[0], r_o[0], f_o[0]}), 32'h19E632);
        wtb_start = 1'b1;
        step();
        wtb_start = 1'b0;
        chk("mid_re", 0, 32'(re_o[0]), 32'd1);
        chk("mid_addr", 0, 32'(addr_o[0]), 32'd0);

        // random mix of ticks, starts and stops
        gap = 2;
        for (int k = 0; k < 1500; k++) begin
            wtb_start = ($urandom_range(0, 149) == 0);
            wtb_stop  = ($urandom_range(0, 149) == 0);
            tstep(3, 8);
        end
        wtb_start = 1'b0;
        wtb_stop = 1'b0;

        // asynchronous reset mid-cycle while playing
        wtb_start = 1'b1;
        step();
        wtb_start = 1'b0;
        repeat (3) tstep(4, 4);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_re", i, 32'(re_o[i]), 32'd0);
            chk("rst_addr", i, 32'(addr_o[i]), 32'd0);
            chk("rst_busy", i, 32'(busy_o[i]), 32'd0);
            chk("rst_ev", i, 32'(ev_o[i]), 32'd0);
            chk("rst_entry", i, 32'({l_o[i], r_o[i], f_o[i]}), 32'd0);
        end
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        gap = 2;
        re_count = 0;
        for (int k = 0; k < 30; k++) begin
            tstep(3, 5);
            if (re_o[0] || busy_o[0]) re_count++;
        end
        chk("post_rst_idle", 0, 32'(re_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
